// File: rtl/selezionatore_nvie_reg.sv
// Registered K-way demultiplexer with valid/ready flow control per way,
// broadcast delivery and a sticky flag for out-of-range selector values.
module selezionatore_nvie_reg #(
    parameter int N     = 32,
    parameter int K     = 8,
    parameter int SEL_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N-1:0]       x,
    input  logic [SEL_W-1:0]   alpha,
    input  logic               bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [K*N-1:0]     z,
    output logic [K-1:0]       out_valid,
    input  logic [K-1:0]       out_ready,
    output logic               err_sel
);

    // Handshake: a word moves on any edge where valid and ready are both high.
    // in_ready never looks at in_valid; out_ready is ignored on an empty way.

    logic [K-1:0]   vld_q, vld_d;
    logic [K*N-1:0] data_q, data_d;
    logic           err_q, err_d;

    logic [K-1:0]   sel_hit;
    logic           sel_in_range;
    logic [K-1:0]   free;
    logic [K-1:0]   load;
    logic           acc;

    // Decoding alpha against each way index also tells us whether alpha < K.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < K; i++) begin
            sel_hit[i] = (alpha == SEL_W'(i));
        end
        sel_in_range = |sel_hit;
    end

    // A way is free when empty or draining this cycle.
    assign free = ~vld_q | out_ready;

    always_comb begin
        if (bcast) begin
            in_ready = &free;
        end else if (sel_in_range) begin
            in_ready = |(sel_hit & free);
        end else begin
            in_ready = 1'b1;
        end
    end

    assign acc = in_valid & in_ready;

    // Broadcast only loads when every way is free, so it is all-or-nothing.
    always_comb begin
        load = '0;
        if (acc) begin
            load = bcast ? {K{1'b1}} : sel_hit;
        end
    end

    always_comb begin
        vld_d  = load | (vld_q & ~out_ready);
        err_d  = err_q | (acc & ~bcast & ~sel_in_range);
        data_d = data_q;
        for (int i = 0; i < K; i++) begin
            if (load[i]) begin
                data_d[i*N +: N] = x;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign z         = data_q;
    assign out_valid = vld_q;
    assign err_sel   = err_q;

endmodule

// File: tb/tb_selezionatore_nvie_reg.sv
// Bench for selezionatore_nvie_reg: an 8-way instance checked through a
// per-way scoreboard, plus a 6-way instance for out-of-range selectors.
module tb_selezionatore_nvie_reg;
  localparam int N = 32;
  localparam int K = 8;
  localparam int SEL_W = 3;
  localparam int N6 = 16;
  localparam int K6 = 6;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // 8-way instance
  logic [N-1:0]     x = '0;
  logic [SEL_W-1:0] alpha = '0;
  logic             bcast = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [K*N-1:0]   z;
  logic [K-1:0]     out_valid;
  logic [K-1:0]     out_ready = '0;
  logic             err_sel;

  // 6-way instance
  logic [N6-1:0]    x6 = '0;
  logic [2:0]       alpha6 = '0;
  logic             bcast6 = 1'b0;
  logic             in_valid6 = 1'b0;
  logic             in_ready6;
  logic [K6*N6-1:0] z6;
  logic [K6-1:0]    out_valid6;
  logic [K6-1:0]    out_ready6 = '0;
  logic             err6;

  selezionatore_nvie_reg #(.N(N), .K(K), .SEL_W(SEL_W)) dut (
    .clock(clock), .reset_n(reset_n), .x(x), .alpha(alpha), .bcast(bcast),
    .in_valid(in_valid), .in_ready(in_ready), .z(z), .out_valid(out_valid),
    .out_ready(out_ready), .err_sel(err_sel)
  );

  selezionatore_nvie_reg #(.N(N6), .K(K6), .SEL_W(3)) dut6 (
    .clock(clock), .reset_n(reset_n), .x(x6), .alpha(alpha6), .bcast(bcast6),
    .in_valid(in_valid6), .in_ready(in_ready6), .z(z6), .out_valid(out_valid6),
    .out_ready(out_ready6), .err_sel(err6)
  );

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [7:0]   way;
    logic [N-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [K-1:0]   vld_m = '0;
  logic [K-1:0]   held_prev = '0;
  logic [K*N-1:0] held_z = '0;

  // reference model of per-way occupancy
  function automatic logic model_ready(logic [K-1:0] v, logic [K-1:0] r,
                                       logic [SEL_W-1:0] a, logic b);
    logic [K-1:0] fr;
    fr = ~v | r;
    if (b) return &fr;
    if (int'(a) < K) return fr[a];
    return 1'b1;
  endfunction

  function automatic logic [K-1:0] model_next(logic [K-1:0] v, logic [K-1:0] r,
                                              logic iv, logic [SEL_W-1:0] a, logic b);
    logic [K-1:0] ld;
    ld = '0;
    if (iv && model_ready(v, r, a, b)) begin
      if (b) ld = '1;
      else if (int'(a) < K) ld[a] = 1'b1;
    end
    return ld | (v & ~r);
  endfunction

  function automatic int find_exp(int way);
    for (int j = 0; j < exp_q.size(); j++) begin
      if (int'(exp_q[j].way) == way) return j;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset_n) vld_m <= model_next(vld_m, out_ready, in_valid, alpha, bcast);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: one offer per cycle; pushes expected words when the model accepts
  task automatic drive(input logic v, input logic [N-1:0] xx, input logic [SEL_W-1:0] aa,
                       input logic bb, input logic [K-1:0] rr, output logic rdy);
    logic exp_rdy;
    @(posedge clock);
    #1;
    in_valid = v; x = xx; alpha = aa; bcast = bb; out_ready = rr;
    @(negedge clock);
    rdy = in_ready;
    exp_rdy = model_ready(vld_m, rr, aa, bb);
    check("in_ready_model", 64'(in_ready), 64'(exp_rdy));
    if (v && exp_rdy) begin
      if (bb) begin
        for (int i = 0; i < K; i++) exp_q.push_back('{way: 8'(i), data: xx});
      end else if (int'(aa) < K) begin
        exp_q.push_back('{way: 8'(aa), data: xx});
      end
    end
  endtask

  // monitor: pops the scoreboard whenever a way hands over a word
  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      total++;
      if (out_valid !== vld_m) begin
        bad++;
        $display("FAIL out_valid: got=%0h expected=%0h", out_valid, vld_m);
      end
      for (int i = 0; i < K; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          automatic int j;
          j = find_exp(i);
          total++;
          if (j < 0) begin
            bad++;
            $display("FAIL unexpected_word way=%0d: got=%0h expected=none", i, z[i*N +: N]);
          end else begin
            if (exp_q[j].data !== z[i*N +: N]) begin
              bad++;
              $display("FAIL data way=%0d: got=%0h expected=%0h", i, z[i*N +: N], exp_q[j].data);
            end
            exp_q.delete(j);
          end
        end
        if (held_prev[i]) begin
          total++;
          if (z[i*N +: N] !== held_z[i*N +: N] || !out_valid[i]) begin
            bad++;
            $display("FAIL hold way=%0d: got=%0h/%0b expected=%0h/1", i, z[i*N +: N],
                     out_valid[i], held_z[i*N +: N]);
          end
        end
      end
      held_prev <= out_valid & ~out_ready;
      held_z <= z;
    end
  end

  initial begin
    logic rdy;
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    mon_en = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_z_nonzero", 64'(z != '0), 64'h0);
    check("rst_err_sel", 64'(err_sel), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_err6", 64'(err6), 64'h0);

    // 1: walk alpha 0..7 with all consumers ready
    for (int i = 0; i < K; i++) begin
      drive(1'b1, 32'h0000_00FF, SEL_W'(i), 1'b0, 8'hFF, rdy);
      check("t1_in_ready", 64'(rdy), 64'h1);
      if (i > 0) check("t1_onehot", 64'(out_valid), 64'(8'h01 << (i - 1)));
    end
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);
    check("t1_onehot_last", 64'(out_valid), 64'h80);
    check("t1_z7", 64'(z[7*N +: N]), 64'h0000_00FF);
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);

    // 2: backpressure on way 3
    drive(1'b1, 32'hA5A5_A5A5, 3'd3, 1'b0, 8'hF7, rdy);
    check("t2_first_ready", 64'(rdy), 64'h1);
    drive(1'b1, 32'hA5A5_A5A5, 3'd3, 1'b0, 8'hF7, rdy);
    check("t2_blocked", 64'(rdy), 64'h0);
    check("t2_held_valid", 64'(out_valid), 64'h08);
    drive(1'b1, 32'hA5A5_A5A5, 3'd3, 1'b0, 8'hFF, rdy);
    check("t2_release_ready", 64'(rdy), 64'h1);
    drive(1'b0, '0, '0, 1'b0, 8'hF7, rdy);
    check("t2_refilled", 64'(out_valid), 64'h08);
    check("t2_z3", 64'(z[3*N +: N]), 64'hA5A5_A5A5);
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);

    // 3: broadcast, then broadcast blocked by a held way
    drive(1'b1, 32'h1234_5678, 3'd0, 1'b1, 8'hFF, rdy);
    check("t3_bcast_ready", 64'(rdy), 64'h1);
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);
    check("t3_all_valid", 64'(out_valid), 64'hFF);
    for (int i = 0; i < K; i++) check("t3_z_slice", 64'(z[i*N +: N]), 64'h1234_5678);
    drive(1'b1, 32'h5555_0005, 3'd5, 1'b0, 8'hDF, rdy);
    check("t3_way5_ready", 64'(rdy), 64'h1);
    drive(1'b1, 32'h9999_9999, 3'd0, 1'b1, 8'hDF, rdy);
    check("t3_bcast_blocked", 64'(rdy), 64'h0);
    check("t3_only_way5", 64'(out_valid), 64'h20);
    drive(1'b0, '0, '0, 1'b0, 8'hDF, rdy);
    check("t3_no_partial", 64'(out_valid), 64'h20);
    check("t3_z5", 64'(z[5*N +: N]), 64'h5555_0005);
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);
    drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);

    // 4: out-of-range selector on the 6-way instance
    @(posedge clock); #1;
    in_valid6 = 1'b1; alpha6 = 3'd2; x6 = 16'hBEEF; out_ready6 = '0;
    @(negedge clock);
    check("t4_in_range_ready", 64'(in_ready6), 64'h1);
    @(posedge clock); #1;
    alpha6 = 3'd7; x6 = 16'h1111;
    @(negedge clock);
    check("t4_way2_valid", 64'(out_valid6), 64'h04);
    check("t4_way2_z", 64'(z6[2*N6 +: N6]), 64'hBEEF);
    check("t4_err_before", 64'(err6), 64'h0);
    check("t4_oor_ready", 64'(in_ready6), 64'h1);
    @(posedge clock); #1;
    alpha6 = 3'd6; x6 = 16'h2222;
    @(negedge clock);
    check("t4_err_set", 64'(err6), 64'h1);
    check("t4_valid_unchanged", 64'(out_valid6), 64'h04);
    check("t4_oor6_ready", 64'(in_ready6), 64'h1);
    @(posedge clock); #1;
    in_valid6 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("t4_err_sticky", 64'(err6), 64'h1);
    check("t4_valid_still", 64'(out_valid6), 64'h04);
    check("t4_z_still", 64'(z6[2*N6 +: N6]), 64'hBEEF);
    @(posedge clock); #1;
    in_valid6 = 1'b1; bcast6 = 1'b1; x6 = 16'h7E57; out_ready6 = '1;
    @(negedge clock);
    check("t4_bcast6_ready", 64'(in_ready6), 64'h1);
    @(posedge clock); #1;
    in_valid6 = 1'b0; bcast6 = 1'b0; out_ready6 = '0;
    @(negedge clock);
    check("t4_bcast6_valid", 64'(out_valid6), 64'h3F);
    check("t4_bcast6_z5", 64'(z6[5*N6 +: N6]), 64'h7E57);
    check("t4_err_after_bcast", 64'(err6), 64'h1);

    // 5: async reset with four held words
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hA0 + i, SEL_W'(i), 1'b0, 8'h00, rdy);
    drive(1'b0, '0, '0, 1'b0, 8'h00, rdy);
    check("t5_held_0f", 64'(out_valid), 64'h0F);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'h0);
    check("t5_rst_z_nonzero", 64'(z != '0), 64'h0);
    check("t5_rst_err", 64'(err_sel), 64'h0);
    check("t5_rst_err6", 64'(err6), 64'h0);
    check("t5_rst_valid6", 64'(out_valid6), 64'h0);
    check("t5_rst_ready", 64'(in_ready), 64'h1);
    vld_m <= '0;
    held_prev <= '0;
    exp_q.delete();
    #1;
    reset_n = 1'b1;

    // random mix checked through the scoreboard
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, SEL_W'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0), K'($urandom_range(0, 255)), rdy);
    end
    repeat (4) drive(1'b0, '0, '0, 1'b0, 8'hFF, rdy);
    check("final_queue_empty", 64'(exp_q.size()), 64'h0);
    check("final_err_clear", 64'(err_sel), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
